// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared constants and requester-index encoding for the two-producer FIFO write arbiter.
package fifo_wr_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_idx_e;

endpackage

// File: rtl/fifo_ptr_flags.sv
// Read/write pointer registers with full, empty and occupancy derived from them.
module fifo_ptr_flags
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic [AW-1:0] waddr,
    output logic [AW-1:0] raddr,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [AW:0] wptr_reg;
    logic [AW:0] rptr_reg;

    // One extra pointer bit tells a full ring from an empty one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
        end else begin
            if (wr_en) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (rd_en) begin
                rptr_reg <= rptr_reg + 1'b1;
            end
        end
    end

    assign waddr = wptr_reg[AW-1:0];
    assign raddr = rptr_reg[AW-1:0];
    assign empty = (wptr_reg == rptr_reg);
    assign full  = (wptr_reg[AW] != rptr_reg[AW]) && (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
    assign count = wptr_reg - rptr_reg;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting one of two producers per cycle into an external FIFO memory.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    input  logic             rd_req,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             ovf,
    output logic             mem_wr_rq,
    output logic             mem_rd_rq,
    output logic [AW-1:0]    mem_waddr,
    output logic [AW-1:0]    mem_raddr,
    output logic [WIDTH-1:0] mem_wdata
);

    req_idx_e rr_last_reg;
    logic     rd_valid_reg;
    logic     ovf_reg;
    logic     wr_en;
    logic     rd_en;

    fifo_ptr_flags #(
        .DEPTH (DEPTH)
    ) u_ptr_flags (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .waddr (mem_waddr),
        .raddr (mem_raddr),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Grants are gated by rst_n so nothing is strobed while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && !full) begin
            if (req0 && req1) begin
                if (rr_last_reg == REQ0) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
            end else if (req0) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        mem_wdata = '0;
        if (gnt0) begin
            mem_wdata = data0;
        end else if (gnt1) begin
            mem_wdata = data1;
        end
    end

    assign wr_en     = gnt0 | gnt1;
    assign rd_en     = rst_n && rd_req && !empty;
    assign mem_wr_rq = wr_en;
    assign mem_rd_rq = rd_en;

    // rr_last starts at REQ1 so producer 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_reg  <= REQ1;
            rd_valid_reg <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            if (gnt0) begin
                rr_last_reg <= REQ0;
            end else if (gnt1) begin
                rr_last_reg <= REQ1;
            end
            rd_valid_reg <= rd_en;
            if ((req0 || req1) && full) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign rd_valid = rd_valid_reg;
    assign ovf      = ovf_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: vector table for arbitration/pointer behaviour plus hand-written corner sequences.
module tb_fifo_wr_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0, req1, rd_req;
    logic [3:0] data0, data1;
    logic       gnt0, gnt1, rd_valid, full, empty, ovf;
    logic [3:0] count;
    logic       mem_wr_rq, mem_rd_rq;
    logic [2:0] mem_waddr, mem_raddr;
    logic [3:0] mem_wdata;

    int checks = 0;
    int errors = 0;

    logic [3:0] mem_model [8];
    logic [3:0] mem_rdata;
    logic [3:0] sb [$];

    fifo_wr_arbiter #(.WIDTH(4), .DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .data0     (data0),
        .data1     (data1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rd_req    (rd_req),
        .rd_valid  (rd_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .ovf       (ovf),
        .mem_wr_rq (mem_wr_rq),
        .mem_rd_rq (mem_rd_rq),
        .mem_waddr (mem_waddr),
        .mem_raddr (mem_raddr),
        .mem_wdata (mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached memory with registered read.
    always @(posedge clk) begin
        if (mem_wr_rq) mem_model[mem_waddr] <= mem_wdata;
        if (mem_rd_rq) mem_rdata <= mem_model[mem_raddr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] e;
        if (rst_n && rd_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_data_unexpected: got %0d expected no read", mem_rdata);
            end else begin
                e = sb.pop_front();
                chk("rd_data", mem_rdata, e);
                $display("read data %0d (expected %0d)", mem_rdata, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r0, input logic r1, input logic [3:0] d0,
                         input logic [3:0] d1, input logic rd);
        req0 = r0; req1 = r1; data0 = d0; data1 = d1; rd_req = rd;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_gnt", {gnt1, gnt0}, 0);
        chk("rst_mem", {mem_wr_rq, mem_rd_rq, mem_waddr, mem_raddr, mem_wdata}, 0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       r0, r1, rd;
        logic [3:0] d0, d1;
        logic       eg0, eg1, erd;
        logic [2:0] ewa, era;
        logic [3:0] ecnt;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [3:0] ew;
        logic [3:0] d;
        int guard;

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);

        // r0 r1 rd d0 d1 | eg0 eg1 erd ewaddr eraddr count_after
        tbl[0]  = '{1, 1, 0, 4'd1,  4'd2,  1, 0, 0, 3'd0, 3'd0, 4'd1};
        tbl[1]  = '{1, 1, 0, 4'd3,  4'd4,  0, 1, 0, 3'd1, 3'd0, 4'd2};
        tbl[2]  = '{1, 1, 0, 4'd5,  4'd6,  1, 0, 0, 3'd2, 3'd0, 4'd3};
        tbl[3]  = '{1, 1, 0, 4'd7,  4'd8,  0, 1, 0, 3'd3, 3'd0, 4'd4};
        tbl[4]  = '{0, 0, 1, 4'd0,  4'd0,  0, 0, 1, 3'd4, 3'd0, 4'd3};
        tbl[5]  = '{0, 0, 0, 4'd0,  4'd0,  0, 0, 0, 3'd4, 3'd1, 4'd3};
        tbl[6]  = '{1, 0, 1, 4'd9,  4'd0,  1, 0, 1, 3'd4, 3'd1, 4'd3};
        tbl[7]  = '{1, 0, 1, 4'd10, 4'd0,  1, 0, 1, 3'd5, 3'd2, 4'd3};
        tbl[8]  = '{1, 0, 1, 4'd11, 4'd0,  1, 0, 1, 3'd6, 3'd3, 4'd3};
        tbl[9]  = '{1, 0, 1, 4'd12, 4'd0,  1, 0, 1, 3'd7, 3'd4, 4'd3};
        tbl[10] = '{1, 0, 1, 4'd13, 4'd0,  1, 0, 1, 3'd0, 3'd5, 4'd3};
        tbl[11] = '{0, 1, 0, 4'd0,  4'd14, 0, 1, 0, 3'd1, 3'd6, 4'd4};
        tbl[12] = '{0, 1, 0, 4'd0,  4'd15, 0, 1, 0, 3'd2, 3'd6, 4'd5};
        tbl[13] = '{1, 1, 0, 4'd1,  4'd2,  1, 0, 0, 3'd3, 3'd6, 4'd6};

        // Table: tie alternation, concurrent read/write, single requesters.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].r0, tbl[i].r1, tbl[i].d0, tbl[i].d1, tbl[i].rd);
            #1;
            ew = tbl[i].eg0 ? tbl[i].d0 : (tbl[i].eg1 ? tbl[i].d1 : 4'd0);
            chk("tbl_gnt0", gnt0, tbl[i].eg0);
            chk("tbl_gnt1", gnt1, tbl[i].eg1);
            chk("tbl_mem_wr_rq", mem_wr_rq, tbl[i].eg0 | tbl[i].eg1);
            chk("tbl_mem_rd_rq", mem_rd_rq, tbl[i].erd);
            chk("tbl_waddr", mem_waddr, tbl[i].ewa);
            chk("tbl_raddr", mem_raddr, tbl[i].era);
            chk("tbl_wdata", mem_wdata, ew);
            if (tbl[i].eg0 || tbl[i].eg1) sb.push_back(ew);
            step();
            chk("tbl_count", count, tbl[i].ecnt);
            chk("tbl_rd_valid", rd_valid, tbl[i].erd);
            $display("vec %0d: gnt=%0d%0d rd=%0d waddr=%0d raddr=%0d count=%0d",
                     i, gnt1, gnt0, tbl[i].erd, tbl[i].ewa, tbl[i].era, count);
        end

        // First write after reset.
        do_reset();
        drive(1, 0, 4'hA, 0, 0);
        #1;
        chk("first_gnt0", gnt0, 1);
        chk("first_gnt1", gnt1, 0);
        chk("first_waddr", mem_waddr, 0);
        chk("first_wdata", mem_wdata, 4'hA);
        sb.push_back(4'hA);
        step();
        chk("first_count", count, 1);
        chk("first_empty", empty, 0);
        drive(0, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        $display("first write: count=%0d empty=%0d", count, empty);

        // Fill, overflow, refused write during read, grant next cycle.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 4'(i), 0, 0);
            #1;
            chk("fill_gnt0", gnt0, 1);
            sb.push_back(4'(i));
            step();
        end
        chk("fill_full", full, 1);
        chk("fill_count", count, 8);
        drive(0, 1, 0, 4'd5, 0);
        #1;
        chk("full_gnt1", gnt1, 0);
        chk("full_wr_rq", mem_wr_rq, 0);
        step();
        chk("ovf_set", ovf, 1);
        drive(0, 1, 0, 4'd6, 1);
        #1;
        chk("full_rd_gnt1", gnt1, 0);
        chk("full_rd_rq", mem_rd_rq, 1);
        step();
        drive(0, 1, 0, 4'd7, 0);
        #1;
        chk("freed_gnt1", gnt1, 1);
        chk("freed_waddr", mem_waddr, 0);
        sb.push_back(4'd7);
        step();
        chk("refill_count", count, 8);
        drive(0, 0, 0, 0, 1);
        guard = 0;
        while (!empty && guard < 20) begin
            step();
            guard++;
        end
        chk("drain_bounded", guard < 20, 1);
        drive(0, 0, 0, 0, 0);
        step();
        chk("drain_empty", empty, 1);
        chk("ovf_sticky", ovf, 1);
        $display("overflow sequence: ovf=%0d empty=%0d", ovf, empty);

        // Two fill/drain passes: address wrap and rd_valid timing.
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 8; i++) begin
                d = 4'($urandom_range(0, 15));
                drive(0, 1, 0, d, 0);
                #1;
                chk("wrap_gnt1", gnt1, 1);
                chk("wrap_waddr", mem_waddr, i);
                sb.push_back(d);
                step();
            end
            chk("wrap_full", full, 1);
            for (int i = 0; i < 8; i++) begin
                drive(0, 0, 0, 0, 1);
                #1;
                chk("wrap_rd_rq", mem_rd_rq, 1);
                chk("wrap_raddr", mem_raddr, i);
                step();
                chk("wrap_rd_valid", rd_valid, 1);
            end
            drive(0, 0, 0, 0, 0);
            step();
            chk("wrap_rd_valid_off", rd_valid, 0);
            chk("wrap_empty", empty, 1);
            $display("pass %0d done: empty=%0d", p, empty);
        end
        drive(0, 0, 0, 0, 1);
        #1;
        chk("empty_rd_rq", mem_rd_rq, 0);
        step();
        chk("empty_rd_valid", rd_valid, 0);
        chk("empty_raddr", mem_raddr, 0);

        // Asynchronous reset mid-cycle at count 5.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 4'(i + 3), 0, 0);
            sb.push_back(4'(i + 3));
            step();
        end
        chk("pre_rst_count", count, 5);
        drive(1, 0, 4'd3, 0, 0);
        #3;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("async_count", count, 0);
        chk("async_empty", empty, 1);
        chk("async_full", full, 0);
        chk("async_gnt0", gnt0, 0);
        chk("async_mem", {mem_wr_rq, mem_waddr, mem_raddr, mem_wdata}, 0);
        step();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 1);
        #1;
        chk("post_rst_rd_rq", mem_rd_rq, 0);
        step();
        chk("post_rst_rd_valid", rd_valid, 0);
        $display("async reset: count=%0d empty=%0d", count, empty);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
